imm_encoder: RTL and testbench

IMM_ENCODER -- requirements
Module: imm_encoder

---
 rtl/imm_encoder.sv | 181 ++++++++++++++++++
 tb/tb_imm_encoder.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_encoder.sv
// RV64 immediate encoder: packs register fields and a 64-bit immediate
// into one instruction word, expanding load-immediate into LUI/ADDI(W).
module imm_encoder (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opcode,
   input  logic [2:0]  in_funct3,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [63:0] in_imm,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_err,
   output logic        out_last
);

   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [6:0]  OP_IMM   = 7'b0010011;
   localparam logic [6:0]  OP_LUI   = 7'b0110111;
   localparam logic [6:0]  OP_IMMW  = 7'b0011011;

   typedef enum logic {
      RUN,
      SECOND
   } state_t;

   state_t      state;
   logic [31:0] pend_inst;

   logic        accept;
   logic        xfer;

   logic        fmt_i, fmt_s, fmt_b;
   logic        fmt_u, fmt_j, fmt_li;

   logic        eq11, eq12, eq20, eq31;
   logic        fit_i, fit_b, fit_u, fit_j;

   logic [11:0] lo12;
   logic [19:0] hi20;

   logic [31:0] enc_inst;
   logic        enc_err;
   logic        enc_last;
   logic        enc_two;
   logic [31:0] enc_pend;

   assign in_ready = (!out_valid || out_ready)
                   && (state == RUN) && !rst;
   assign accept   = in_valid && in_ready;
   assign xfer     = out_valid && out_ready;

   assign fmt_i  = (in_fmt == 3'd0);
   assign fmt_s  = (in_fmt == 3'd1);
   assign fmt_b  = (in_fmt == 3'd2);
   assign fmt_u  = (in_fmt == 3'd3);
   assign fmt_j  = (in_fmt == 3'd4);
   assign fmt_li = (in_fmt == 3'd5);

   // An N-bit signed value fits when every bit above N-1 copies the sign.
   assign eq11 = (&in_imm[63:11]) | ~(|in_imm[63:11]);
   assign eq12 = (&in_imm[63:12]) | ~(|in_imm[63:12]);
   assign eq20 = (&in_imm[63:20]) | ~(|in_imm[63:20]);
   assign eq31 = (&in_imm[63:31]) | ~(|in_imm[63:31]);

   assign fit_i = eq11;
   assign fit_b = eq12 && !in_imm[0];
   assign fit_j = eq20 && !in_imm[0];
   assign fit_u = eq31 && (in_imm[11:0] == 12'd0);

   // Rounding the upper part absorbs the sign of lo12 in the ADDI(W).
   assign lo12 = in_imm[11:0];
   assign hi20 = in_imm[31:12] + {19'd0, in_imm[11]};

   always_comb begin
      enc_inst = NOP;
      enc_err  = 1'b1;
      enc_last = 1'b1;
      enc_two  = 1'b0;
      enc_pend = NOP;
      unique case (1'b1)
         fmt_i: begin
            if (fit_i) begin
               enc_inst = {in_imm[11:0], in_rs1, in_funct3,
                           in_rd, in_opcode};
               enc_err  = 1'b0;
            end
         end
         fmt_s: begin
            if (fit_i) begin
               enc_inst = {in_imm[11:5], in_rs2, in_rs1,
                           in_funct3, in_imm[4:0], in_opcode};
               enc_err  = 1'b0;
            end
         end
         fmt_b: begin
            if (fit_b) begin
               enc_inst = {in_imm[12], in_imm[10:5], in_rs2,
                           in_rs1, in_funct3, in_imm[4:1],
                           in_imm[11], in_opcode};
               enc_err  = 1'b0;
            end
         end
         fmt_u: begin
            if (fit_u) begin
               enc_inst = {in_imm[31:12], in_rd, in_opcode};
               enc_err  = 1'b0;
            end
         end
         fmt_j: begin
            if (fit_j) begin
               enc_inst = {in_imm[20], in_imm[10:1], in_imm[11],
                           in_imm[19:12], in_rd, in_opcode};
               enc_err  = 1'b0;
            end
         end
         fmt_li: begin
            if (eq31) begin
               enc_err = 1'b0;
               if (hi20 == 20'd0) begin
                  enc_inst = {lo12, 5'd0, 3'b000, in_rd, OP_IMM};
               end else if (lo12 == 12'd0) begin
                  enc_inst = {hi20, in_rd, OP_LUI};
               end else begin
                  enc_inst = {hi20, in_rd, OP_LUI};
                  enc_last = 1'b0;
                  enc_two  = 1'b1;
                  enc_pend = {lo12, in_rd, 3'b000, in_rd, OP_IMMW};
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         out_valid <= 1'b0;
         out_inst  <= 32'd0;
         out_err   <= 1'b0;
         out_last  <= 1'b0;
         pend_inst <= 32'd0;
      end else begin
         unique case (state)
            RUN: begin
               if (accept) begin
                  out_valid <= 1'b1;
                  out_inst  <= enc_inst;
                  out_err   <= enc_err;
                  out_last  <= enc_last;
                  if (enc_two) begin
                     pend_inst <= enc_pend;
                     state     <= SECOND;
                  end
               end else if (xfer) begin
                  out_valid <= 1'b0;
               end
            end
            SECOND: begin
               if (xfer) begin
                  out_inst <= pend_inst;
                  out_err  <= 1'b0;
                  out_last <= 1'b1;
                  state    <= RUN;
               end
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: requests push expected words,
// a monitor pops and compares every transfer.
module tb_imm_encoder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opcode;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [63:0] in_imm;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic        out_err;
   logic        out_last;

   int vectors     = 0;
   int miscompares = 0;
   int st;

   logic [33:0] sb[$];

   localparam logic [33:0] ERR = {32'h0000_0013, 1'b1, 1'b1};
   localparam logic [33:0] NX  = 34'd0;

   imm_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_fmt    (in_fmt),
      .in_opcode (in_opcode),
      .in_funct3 (in_funct3),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_inst  (out_inst),
      .out_err   (out_err),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [33:0] ok(input logic [31:0] i,
                                      input logic l);
      return {i, 1'b0, l};
   endfunction

   // scoreboard monitor: every transfer must match the oldest expectation
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         logic [33:0] e;
         vectors++;
         if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL word unexpected got inst=%h err=%b last=%b",
                     out_inst, out_err, out_last);
         end else begin
            e = sb.pop_front();
            if ({out_inst, out_err, out_last} !== e) begin
               miscompares++;
               $display("FAIL word got inst=%h err=%b last=%b want inst=%h err=%b last=%b",
                        out_inst, out_err, out_last, e[33:2], e[1], e[0]);
            end
         end
      end
   end

   task automatic send(input logic [2:0] f, input logic [6:0] op,
                       input logic [2:0] f3, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [63:0] imm, input logic [33:0] e0,
                       input logic two, input logic [33:0] e1,
                       output int stalls);
      in_fmt = f; in_opcode = op; in_funct3 = f3;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      stalls = 0;
      @(negedge clk);
      while (!in_ready && stalls < 50) begin
         stalls++;
         @(negedge clk);
      end
      if (!in_ready) begin
         vectors++; miscompares++;
         $display("FAIL accept_timeout got in_ready=0 want 1");
      end else begin
         sb.push_back(e0);
         if (two) sb.push_back(e1);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk); #1;
         n++;
      end
      if (sb.size() != 0) begin
         vectors++; miscompares++;
         $display("FAIL drain got %0d pending want 0", sb.size());
         sb.delete();
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({out_valid, out_inst, out_err, out_last} !== 35'd0) begin
         miscompares++;
         $display("FAIL reset_out got v=%b inst=%h e=%b l=%b want zeros",
                  out_valid, out_inst, out_err, out_last);
      end
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ready got %b want 0", in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL first_ready got %b want 1", in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_i_s();
      send(3'd0, 7'h13, 3'd0, 5'd5, 5'd6, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF,
           ok(32'hFFF3_0293, 1'b1), 1'b0, NX, st);
      send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2047,
           ok(32'h7FF0_0093, 1'b1), 1'b0, NX, st);
      send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_F800,
           ok(32'h8000_0093, 1'b1), 1'b0, NX, st);
      send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd2048,
           ERR, 1'b0, NX, st);
      send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'h0000_0001_0000_0000,
           ERR, 1'b0, NX, st);
      send(3'd1, 7'h23, 3'd3, 5'd0, 5'd2, 5'd8, 64'd16,
           ok(32'h0081_3823, 1'b1), 1'b0, NX, st);
      send(3'd1, 7'h23, 3'd3, 5'd0, 5'd2, 5'd8, 64'hFFFF_FFFF_FFFF_F7FF,
           ERR, 1'b0, NX, st);
      drain();
   endtask

   task automatic test_b_u_j();
      send(3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 64'd4096,
           ERR, 1'b0, NX, st);
      send(3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 64'd3,
           ERR, 1'b0, NX, st);
      send(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 64'hFFFF_FFFF_FFFF_FFFC,
           ok(32'hFE20_8EE3, 1'b1), 1'b0, NX, st);
      send(3'd2, 7'h63, 3'd0, 5'd0, 5'd0, 5'd0, 64'd4094,
           ok(32'h7E00_0FE3, 1'b1), 1'b0, NX, st);
      send(3'd3, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5000,
           ok(32'h1234_52B7, 1'b1), 1'b0, NX, st);
      send(3'd3, 7'h37, 3'd0, 5'd5, 5'd0, 5'd0, 64'h1234_5001,
           ERR, 1'b0, NX, st);
      send(3'd3, 7'h37, 3'd0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_8000_0000,
           ok(32'h8000_0037, 1'b1), 1'b0, NX, st);
      send(3'd3, 7'h37, 3'd0, 5'd0, 5'd0, 5'd0, 64'h8000_0000,
           ERR, 1'b0, NX, st);
      send(3'd4, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 64'h800,
           ok(32'h0010_00EF, 1'b1), 1'b0, NX, st);
      send(3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFE,
           ok(32'hFFFF_F06F, 1'b1), 1'b0, NX, st);
      send(3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 64'd1048576,
           ERR, 1'b0, NX, st);
      send(3'd4, 7'h6F, 3'd0, 5'd0, 5'd0, 5'd0, 64'd1,
           ERR, 1'b0, NX, st);
      send(3'd6, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd0,
           ERR, 1'b0, NX, st);
      send(3'd7, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd0,
           ERR, 1'b0, NX, st);
      drain();
   endtask

   task automatic test_li();
      send(3'd5, 7'h00, 3'd7, 5'd10, 5'd3, 5'd4, 64'h1234_5678,
           ok(32'h1234_5537, 1'b0), 1'b1, ok(32'h6785_051B, 1'b1), st);
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0) begin
         miscompares++;
         $display("FAIL li_gap_ready got %b want 0", in_ready);
      end
      @(posedge clk); #1;
      send(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 64'h800,
           ok(32'h0000_1537, 1'b0), 1'b1, ok(32'h8005_051B, 1'b1), st);
      send(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 64'hFFFF_FFFF_FFFF_FFFB,
           ok(32'hFFB0_0513, 1'b1), 1'b0, NX, st);
      send(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 64'h8000_0000,
           ERR, 1'b0, NX, st);
      send(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 64'h1000,
           ok(32'h0000_1537, 1'b1), 1'b0, NX, st);
      send(3'd5, 7'h00, 3'd0, 5'd0, 5'd0, 5'd0, 64'd5,
           ok(32'h0050_0013, 1'b1), 1'b0, NX, st);
      drain();
   endtask

   task automatic test_back_to_back();
      int total = 0;
      for (int i = 0; i < 6; i++) begin
         send(3'd0, 7'h13, 3'd0, 5'(i + 1), 5'd0, 5'd0, 64'(i * 3),
              ok({12'(i * 3), 5'd0, 3'd0, 5'(i + 1), 7'h13}, 1'b1),
              1'b0, NX, st);
         total += st;
      end
      vectors++;
      if (total !== 0) begin
         miscompares++;
         $display("FAIL b2b_stalls got %0d want 0", total);
      end
      send(3'd5, 7'h00, 3'd0, 5'd10, 5'd0, 5'd0, 64'h1234_5678,
           ok(32'h1234_5537, 1'b0), 1'b1, ok(32'h6785_051B, 1'b1), st);
      send(3'd0, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 64'd7,
           ok(32'h0070_0093, 1'b1), 1'b0, NX, st);
      vectors++;
      if (st !== 1) begin
         miscompares++;
         $display("FAIL li_stall got %0d want 1", st);
      end
      drain();
   endtask

   task automatic test_stall();
      out_ready = 1'b0;
      in_fmt = 3'd0; in_opcode = 7'h13; in_funct3 = 3'd0;
      in_rd = 5'd1; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 64'd7;
      in_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_first_ready got %b want 1", in_ready);
      end
      sb.push_back(ok(32'h0070_0093, 1'b1));
      @(posedge clk); #1;
      in_rd = 5'd2; in_imm = 64'd9;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         vectors++;
         if ({out_valid, out_inst, in_ready} !== {1'b1, 32'h0070_0093, 1'b0}) begin
            miscompares++;
            $display("FAIL stall_hold got v=%b inst=%h rdy=%b want 1 00700093 0",
                     out_valid, out_inst, in_ready);
         end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL stall_release got %b want 1", in_ready);
      end
      sb.push_back(ok(32'h0090_0113, 1'b1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();
   endtask

   task automatic test_reset_second();
      out_ready = 1'b0;
      in_fmt = 3'd5; in_rd = 5'd10; in_imm = 64'h1234_5678;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      vectors++;
      if ({out_valid, out_inst} !== 33'd0) begin
         miscompares++;
         $display("FAIL rst_second got v=%b inst=%h want 0 0",
                  out_valid, out_inst);
      end
      vectors++;
      if (in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_second_ready got %b want 1", in_ready);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         vectors++;
         if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_no_addiw got v=%b inst=%h want 0",
                     out_valid, out_inst);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      in_fmt = 3'd0; in_opcode = 7'd0; in_funct3 = 3'd0;
      in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_imm = 64'd0;
      test_reset();
      test_i_s();
      test_b_u_j();
      test_li();
      test_back_to_back();
      test_stall();
      test_reset_second();
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
